// File: rtl/prog_loader.sv
// prog_loader: serial program loader feeding the program-memory write port.
// Stream: 16-bit word count N (MSB first), N instructions (MSB byte first),
// then one checksum byte equal to the mod-256 sum of header and payload bytes.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// HDR_HI | waiting for header high byte
// HDR_LO | waiting for header low byte, range-checks N
// DATA   | assembling bytes of the current instruction
// WRITE  | memory write cycle (mem_we high, rx_ready low)
// CSUM   | waiting for checksum byte
// DONE   | last load succeeded, processor released
// ERR    | last load failed, processor held
module prog_loader #(
  parameter int INSTR_WIDTH = 32,
  parameter int MEM_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   rx_valid_i,
  input  logic [7:0]             rx_data_i,
  output logic                   rx_ready_o,
  output logic                   mem_we_o,
  output logic [MEM_WIDTH-1:0]   mem_addr_o,
  output logic [INSTR_WIDTH-1:0] mem_data_o,
  output logic                   cpu_hold_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [MEM_WIDTH:0]     words_loaded_o
);

  localparam int BYTES = INSTR_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  // Bytes held between beats: everything but the byte that completes a word.
  localparam int PW    = (BYTES > 1) ? (BYTES - 1) * 8 : 8;
  localparam logic [16:0]      DEPTH    = 17'(2 ** MEM_WIDTH);
  localparam logic [BCW-1:0]   LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [MEM_WIDTH:0] ONE_W  = (MEM_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                 state_q;
  logic [7:0]             hdr_hi_q;
  logic [16:0]            n_q;
  logic [BCW-1:0]         byte_cnt_q;
  logic [PW-1:0]          word_q;
  logic [7:0]             csum_q;
  logic                   mem_we_q;
  logic [MEM_WIDTH-1:0]   mem_addr_q;
  logic [INSTR_WIDTH-1:0] mem_data_q;
  logic                   cpu_hold_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic [MEM_WIDTH:0]     words_q;

  logic                   take;
  logic [16:0]            n_d;
  logic [7:0]             csum_d;
  logic [INSTR_WIDTH-1:0] word_d;
  logic [PW-1:0]          word_keep;

  assign rx_ready_o = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
  assign take   = rx_valid_i && rx_ready_o;
  assign n_d    = {1'b0, hdr_hi_q, rx_data_i};
  assign csum_d = csum_q + rx_data_i;

  if (BYTES > 1) begin : g_multi
    assign word_d    = {word_q, rx_data_i};
    assign word_keep = word_d[PW-1:0];
  end else begin : g_single
    assign word_d    = rx_data_i;
    assign word_keep = rx_data_i;
  end

  // Single FSM: sequencing, byte assembly, memory write port and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hdr_hi_q   <= '0;
      n_q        <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      words_q    <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_q    <= S_HDR_HI;
            busy_q     <= 1'b1;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
            csum_q     <= '0;
          end
        end
        S_HDR_HI: begin
          if (take) begin
            hdr_hi_q <= rx_data_i;
            csum_q   <= csum_d;
            state_q  <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (take) begin
            csum_q     <= csum_d;
            n_q        <= n_d;
            byte_cnt_q <= '0;
            if ((n_d == 17'd0) || (n_d > DEPTH)) begin
              state_q <= S_ERR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            csum_q <= csum_d;
            word_q <= word_keep;
            if (byte_cnt_q == LAST_BYTE) begin
              state_q    <= S_WRITE;
              byte_cnt_q <= '0;
              mem_we_q   <= 1'b1;
              mem_addr_q <= words_q[MEM_WIDTH-1:0];
              mem_data_q <= word_d;
              words_q    <= words_q + ONE_W;
            end else begin
              byte_cnt_q <= byte_cnt_q + BCW'(1);
            end
          end
        end
        S_WRITE: begin
          // words_q already counts the word being written this cycle.
          state_q <= (17'(words_q) == n_q) ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (take) begin
            busy_q <= 1'b0;
            if (rx_data_i == csum_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_data_o     = mem_data_q;
  assign cpu_hold_o     = cpu_hold_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed scenarios plus randomized loads, checked
// against a stream/outcome model built from the load format rules.
module tb_prog_loader;
  localparam int W     = 32;
  localparam int MW    = 8;
  localparam int BYTES = W / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, mem_we, cpu_hold, busy, done, error;
  logic [MW-1:0] mem_addr;
  logic [W-1:0]  mem_data;
  logic [MW:0]   words_loaded;

  prog_loader #(.INSTR_WIDTH(W), .MEM_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .rx_valid_i(rx_valid),
    .rx_data_i(rx_data), .rx_ready_o(rx_ready), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .cpu_hold_o(cpu_hold),
    .busy_o(busy), .done_o(done), .error_o(error), .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]    q_bytes[$];
  logic [W-1:0]  exp_words[$];
  logic [MW-1:0] wl_addr[$];
  logic [W-1:0]  wl_data[$];
  logic          prev_we = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: log writes, rx_ready low in write cycles, no back-to-back we.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wl_addr.push_back(mem_addr);
      wl_data.push_back(mem_data);
      check("we_rx_ready_low", rx_ready, 0);
      check("we_not_consecutive", prev_we, 0);
    end
    prev_we = mem_we;
  end

  // Build the byte stream from a word count and exp_words; invalid counts get header only.
  task automatic build_stream(input int n, input bit corrupt);
    logic [7:0] sum;
    q_bytes.delete();
    q_bytes.push_back(8'(n >> 8));
    q_bytes.push_back(8'(n));
    if (n >= 1 && n <= (1 << MW)) begin
      for (int k = 0; k < n; k++)
        for (int b = BYTES - 1; b >= 0; b--)
          q_bytes.push_back(8'(exp_words[k] >> (8 * b)));
      sum = 8'h00;
      foreach (q_bytes[j]) sum = sum + q_bytes[j];
      q_bytes.push_back(corrupt ? sum + 8'h01 : sum);
    end
  endtask

  task automatic random_words(input int n);
    exp_words.delete();
    for (int k = 0; k < n; k++) exp_words.push_back($urandom());
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ":rx_ready"}, rx_ready, 0);
    check({tag, ":mem_we"}, mem_we, 0);
    check({tag, ":mem_addr"}, mem_addr, 0);
    check({tag, ":mem_data"}, mem_data, 0);
    check({tag, ":cpu_hold"}, cpu_hold, 0);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":done"}, done, 0);
    check({tag, ":error"}, error, 0);
    check({tag, ":words"}, words_loaded, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic start_load(input string tag);
    wl_addr.delete();
    wl_data.delete();
    pulse_start();
    @(negedge clk);
    check({tag, ":start_busy"}, busy, 1);
    check({tag, ":start_hold"}, cpu_hold, 1);
    check({tag, ":start_ready"}, rx_ready, 1);
    check({tag, ":start_done"}, done, 0);
    check({tag, ":start_error"}, error, 0);
    check({tag, ":start_words"}, words_loaded, 0);
  endtask

  // Present q_bytes[from..to-1]; with bubbles, rx_valid drops randomly but never
  // while a byte is waiting on a not-ready cycle.
  task automatic send(input bit bubbles, input int from, input int to);
    int i = from;
    int cyc = 0;
    bit pend = 0;
    while (i < to) begin
      @(negedge clk);
      cyc++;
      if (cyc > 40 * (to - from) + 100) begin
        check("send_timeout", i, to);
        break;
      end
      if (bubbles && !pend && $urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
      end else begin
        rx_valid = 1'b1;
        rx_data  = q_bytes[i];
        if (rx_ready) begin
          i++;
          pend = 0;
        end else begin
          pend = 1;
        end
      end
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Outcome checks on the cycle after the final byte of a load.
  task automatic verify(input string tag, input int n, input bit corrupt);
    bit valid = (n >= 1 && n <= (1 << MW));
    bit ok = valid && !corrupt;
    int nw = valid ? n : 0;
    @(negedge clk);
    check({tag, ":done"}, done, ok);
    check({tag, ":error"}, error, !ok);
    check({tag, ":cpu_hold"}, cpu_hold, !ok);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":words"}, words_loaded, nw);
    check({tag, ":rx_ready"}, rx_ready, 0);
    check({tag, ":nwrites"}, wl_addr.size(), nw);
    for (int k = 0; k < nw; k++) begin
      if (k < wl_addr.size()) begin
        check({tag, ":addr"}, wl_addr[k], k);
        check({tag, ":data"}, wl_data[k], exp_words[k]);
      end
    end
  endtask

  task automatic load_s1_words();
    exp_words.delete();
    exp_words.push_back(32'h12345678);
    exp_words.push_back(32'h9ABCDEF0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit bad;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Nominal load, continuous rx_valid.
    load_s1_words();
    build_stream(2, 0);
    check("s1_csum_byte", q_bytes[10], 8'h3A);
    start_load("s1");
    send(0, 0, q_bytes.size());
    verify("s1", 2, 0);
    check("s1_addr_hold", mem_addr, 1);
    check("s1_data_hold", mem_data, 32'h9ABCDEF0);

    // rx_valid after done is ignored.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = 8'h55;
      check("idle_rx_ready", rx_ready, 0);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("idle_nwrites", wl_addr.size(), 2);
    check("idle_done", done, 1);

    // Zero-length header.
    build_stream(0, 0);
    start_load("s2");
    send(0, 0, q_bytes.size());
    verify("s2", 0, 0);

    // Bad checksum.
    load_s1_words();
    build_stream(2, 1);
    check("s3_csum_byte", q_bytes[10], 8'h3B);
    start_load("s3");
    send(0, 0, q_bytes.size());
    verify("s3", 2, 1);

    // Back-pressure and bubbles, same contents as nominal.
    load_s1_words();
    build_stream(2, 0);
    start_load("s4");
    send(1, 0, q_bytes.size());
    verify("s4", 2, 0);

    // start while busy is ignored.
    load_s1_words();
    build_stream(2, 0);
    start_load("busy");
    send(0, 0, 2);
    pulse_start();
    @(negedge clk);
    check("busy_start_busy", busy, 1);
    send(0, 2, q_bytes.size());
    verify("busy", 2, 0);

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      bad = ($urandom_range(0, 3) == 0);
      random_words(n);
      build_stream(n, bad);
      start_load("rnd");
      send(1, 0, q_bytes.size());
      verify("rnd", n, bad);
    end

    // Depth boundary.
    random_words(256);
    build_stream(256, 0);
    start_load("s5_full");
    send(1, 0, q_bytes.size());
    verify("s5_full", 256, 0);
    check("s5_last_addr", mem_addr, 8'hFF);

    exp_words.delete();
    build_stream(257, 0);
    start_load("s5_over");
    send(0, 0, q_bytes.size());
    verify("s5_over", 257, 0);

    // Reset mid-load after 3 bytes of word 1, then a full restart.
    load_s1_words();
    build_stream(2, 0);
    start_load("s6a");
    send(0, 0, 9);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("s6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    start_load("s6");
    send(0, 0, q_bytes.size());
    verify("s6", 2, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader: the write-side front end of the program memory. Accepts a byte stream (header, instruction words, checksum) over a valid/ready handshake. Assembles bytes into INSTR_WIDTH-bit instructions and writes them to consecutive program-memory addresses from 0 through the memory's we/addr/data_in port. Holds the processor in reset while loading and reports done or error.

## Interface

**Parameters**
- INSTR_WIDTH, 32: instruction width in bits. Must be a multiple of 8 and at least 8. BYTES = INSTR_WIDTH/8.
- MEM_WIDTH, 8: program-memory address width, at most 16. Depth = 2^MEM_WIDTH.

**Ports**
- clk, input, 1: clock. All state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: load request, one-cycle pulse.
- rx_valid, input, 1: byte available.
- rx_data, input, 8: byte value.
- rx_ready, output, 1: loader accepts a byte this cycle.
- mem_we, output, 1: program-memory write enable.
- mem_addr, output, MEM_WIDTH: program-memory address.
- mem_data, output, INSTR_WIDTH: instruction word to write.
- cpu_hold, output, 1: keep the processor in reset.
- busy, output, 1: load in progress.
- done, output, 1: sticky; last load succeeded.
- error, output, 1: sticky; last load failed.
- words_loaded, output, MEM_WIDTH+1: words written in the current or last load.

## Operation

**Byte transfer**
- A byte is taken on a rising edge where rx_valid && rx_ready.
- rx_data is ignored otherwise.

**Stream format**
- Header: N, 16 bits, MSB byte first.
- Payload: N words, BYTES bytes each, most-significant byte first.
- Checksum: one byte.

**States**

- **IDLE**
  - start → HDR_HI.
  - Clears done, error, words_loaded and the checksum accumulator.
  - Sets busy and cpu_hold.
- **HDR_HI**
  - rx_ready=1.
  - On byte → HDR_LO.
- **HDR_LO**
  - rx_ready=1.
  - On byte, N is known:
    - N==0 or N>2^MEM_WIDTH → ERR.
    - Otherwise → DATA.
- **DATA**
  - rx_ready=1, except in the write cycle.
  - Bytes are shifted into the word register.
  - When the BYTES-th byte of a word is accepted, the next cycle is the write cycle:
    - mem_we=1, mem_addr=word index, mem_data=assembled word.
    - words_loaded increments.
  - After the write of word N−1 → CSUM.
- **CSUM**
  - rx_ready=1.
  - On byte: if it equals the 8-bit sum (mod 256) of all header and payload bytes → DONE, otherwise → ERR.
- **DONE**
  - done=1, busy=0, cpu_hold=0.
  - start → HDR_HI with the same clears as from IDLE.
- **ERR**
  - error=1, busy=0, cpu_hold=1. The program is partially written, so the processor stays held.
  - start → HDR_HI with the same clears as from IDLE.

**Rules and boundary conditions**
- start while busy: ignored.
- rx_valid outside HDR_HI/HDR_LO/DATA/CSUM: ignored; rx_ready=0.
- The checksum accumulator is 8 bits and wraps.
- words_loaded counts up to 2^MEM_WIDTH.
- mem_addr wraps never: N is range-checked, so the highest written address is 2^MEM_WIDTH−1.
- mem_addr and mem_data hold their last values when mem_we=0.
- Reset mid-load: outputs return to their reset values and the state goes to IDLE. Words already written stay in memory. A later start loads from address 0.

## Timing

**Reset values**
- rx_ready=0, mem_we=0, mem_addr=0, mem_data=0.
- cpu_hold=0: the memory's initialization image runs.
- busy=0, done=0, error=0, words_loaded=0.
- State IDLE.

**Cycle-level behaviour**
- start sampled high at edge t → busy=1, cpu_hold=1, rx_ready=1 from cycle t+1.
- Last byte of word k accepted at edge t:
  - Cycle t+1: mem_we=1, mem_addr=k, rx_ready=0.
  - Cycle t+2: mem_we=0. rx_ready=1 if more words remain or the state is CSUM.
- Minimum load time with continuous rx_valid: 2 + N·(BYTES+1) + 1 cycles after start.
- Checksum accepted at edge t → done or error from cycle t+1. busy=0 from the same cycle.
- mem_we is never high for two consecutive cycles.

## Test plan

1. **Nominal load** (INSTR_WIDTH=32, MEM_WIDTH=8)
   - Stimulus: start; bytes 00 02 12 34 56 78 9A BC DE F0 3A.
   - Required: write addr0=0x12345678, write addr1=0x9ABCDEF0; done=1; error=0; cpu_hold=0; words_loaded=2.
2. **Zero-length header**
   - Stimulus: start; header 00 00.
   - Required: error=1 on the cycle after the second header byte; no mem_we; cpu_hold=1; busy=0.
3. **Bad checksum**
   - Stimulus: the scenario 1 stream with checksum 0x3B.
   - Required: both writes still occur; error=1; done=0; cpu_hold=1.
4. **Back-pressure and bubbles**
   - Stimulus: rx_valid toggled randomly; rx_valid held high across write cycles.
   - Required: rx_ready=0 exactly in the write cycles; no byte lost or duplicated; same memory contents as scenario 1.
5. **Depth boundary** (MEM_WIDTH=8)
   - Stimulus: header 0x0100 with 256 words.
   - Required: last write at addr 0xFF; done=1.
   - Stimulus: header 0x0101.
   - Required: error=1; no writes.
6. **Reset and restart**
   - Stimulus: rst_n low during DATA after 3 bytes of word 1.
   - Required: all outputs at reset values immediately (asynchronous). A new start and the scenario 1 stream write from addr 0 and reach done=1.
